// File: rtl/boid_speed_clamp.sv
// boid_speed_clamp: final velocity stage of the boid update path.
// Estimates speed as max(|vx|,|vy|) + min(|vx|,|vy|)/2 and, when it lies
// outside [MIN_SPEED, MAX_SPEED], rescales both components by
// ratio = target/speed. The ratio comes from a bit-serial restoring divider
// that produces one quotient bit per cycle. All values are signed fix15.
module boid_speed_clamp #(
  parameter logic [31:0] MAX_SPEED = 32'h00030000,
  parameter logic [31:0] MIN_SPEED = 32'h00018000,
  parameter int unsigned DIV_BITS  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] vx_in,
  input  logic [31:0] vy_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] vx_out,
  output logic [31:0] vy_out,
  output logic [1:0]  clamp_flag
);

  localparam int          CNT_W   = $clog2(DIV_BITS + 1);
  localparam logic [31:0] SAT_POS = 32'h7FFFFFFF;
  // 1.0 in fix15; pass-through pairs go through the multipliers unchanged.
  localparam logic [63:0] UNITY   = 64'h0000_0000_0000_8000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPEED,
    S_DIV,
    S_SCALE,
    S_DONE
  } state_t;

  // |v| with the most negative value saturating to the largest positive one.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] v);
    if (v[31] && (v[30:0] == '0)) return SAT_POS;
    else if (v[31])                return $unsigned(-v);
    else                           return $unsigned(v);
  endfunction

  // Speed estimate: max + min/2, saturating when the sum leaves 31 bits.
  function automatic logic [31:0] amax_bmin(input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] mx;
    logic [31:0] mn;
    logic [32:0] sum;
    mx  = (a >= b) ? a : b;
    mn  = (a >= b) ? b : a;
    sum = {1'b0, mx} + 33'(mn >> 1);
    return (sum > {1'b0, SAT_POS}) ? SAT_POS : sum[31:0];
  endfunction

  // Signed fix15 multiply: 64-bit product, arithmetic >>15, keep low 32 bits.
  function automatic logic signed [31:0] fix15_mul(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return 32'(p >>> 15);
  endfunction

  // Quotient saturation: an early overflow or a value above 31 bits clips.
  function automatic logic signed [31:0] ratio_sat(input logic [63:0] q,
                                                    input logic        ovf);
    if (ovf || (q > {32'b0, SAT_POS})) return $signed(SAT_POS);
    else                               return $signed(q[31:0]);
  endfunction

  state_t             state_q,     state_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic signed [31:0] vx_q,        vx_d;
  logic signed [31:0] vy_q,        vy_d;
  logic signed [31:0] vx_out_q,    vx_out_d;
  logic signed [31:0] vy_out_q,    vy_out_d;
  logic [1:0]         flag_q,      flag_d;
  logic [31:0]        den_q,       den_d;
  logic [63:0]        rem_q,       rem_d;
  logic [63:0]        num_q,       num_d;
  logic [63:0]        quo_q,       quo_d;
  logic               ovf_q,       ovf_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;

  logic [31:0]        speed;
  logic [31:0]        target;
  logic [63:0]        dvd;
  logic [64:0]        rem_sh;
  logic signed [31:0] ratio;

  // Next-state and datapath for the accept / speed / divide / scale / hold sequence.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    vx_out_d    = vx_out_q;
    vy_out_d    = vy_out_q;
    flag_d      = flag_q;
    den_d       = den_q;
    rem_d       = rem_q;
    num_d       = num_q;
    quo_d       = quo_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    target      = MAX_SPEED;
    dvd         = '0;
    rem_sh      = '0;
    speed       = amax_bmin(abs_sat(vx_q), abs_sat(vy_q));
    ratio       = ratio_sat(quo_q, ovf_q);

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          vx_d    = $signed(vx_in);
          vy_d    = $signed(vy_in);
          state_d = S_SPEED;
        end
      end

      S_SPEED: begin
        if (speed > MAX_SPEED) begin
          flag_d = 2'b01;
          target = MAX_SPEED;
        end else if ((speed != '0) && (speed < MIN_SPEED)) begin
          flag_d = 2'b10;
          target = MIN_SPEED;
        end else begin
          flag_d = 2'b00;
        end
        // 47-bit dividend target<<15; the part above the quotient width
        // seeds the remainder, the rest is shifted in one bit per cycle.
        dvd = {17'b0, target, 15'b0};
        if (flag_d == 2'b00) begin
          quo_d   = UNITY;
          ovf_d   = 1'b0;
          state_d = S_SCALE;
        end else begin
          den_d   = speed;
          rem_d   = dvd >> DIV_BITS;
          num_d   = dvd << (64 - DIV_BITS);
          quo_d   = '0;
          ovf_d   = (dvd >> DIV_BITS) >= {32'b0, speed};
          cnt_d   = CNT_W'(DIV_BITS);
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        rem_sh = {rem_q, num_q[63]};
        if (rem_sh >= {33'b0, den_q}) begin
          rem_d = 64'(rem_sh - {33'b0, den_q});
          quo_d = {quo_q[62:0], 1'b1};
        end else begin
          rem_d = 64'(rem_sh);
          quo_d = {quo_q[62:0], 1'b0};
        end
        num_d = {num_q[62:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_SCALE;
      end

      S_SCALE: begin
        vx_out_d    = fix15_mul(vx_q, ratio);
        vy_out_d    = fix15_mul(vy_q, ratio);
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  // State, handshake and datapath registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      vx_q        <= '0;
      vy_q        <= '0;
      vx_out_q    <= '0;
      vy_out_q    <= '0;
      flag_q      <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      num_q       <= '0;
      quo_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      vx_out_q    <= vx_out_d;
      vy_out_q    <= vy_out_d;
      flag_q      <= flag_d;
      den_q       <= den_d;
      rem_q       <= rem_d;
      num_q       <= num_d;
      quo_q       <= quo_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign vx_out     = vx_out_q;
  assign vy_out     = vy_out_q;
  assign clamp_flag = flag_q;

endmodule

// File: tb/tb_boid_speed_clamp.sv
// Testbench for boid_speed_clamp: directed vector table, backpressure and
// mid-divide reset sequences, then random pairs checked against an
// integer-arithmetic model of the speed clamp.
module tb_boid_speed_clamp;

  localparam logic [31:0] MAX_SPEED = 32'h00030000;
  localparam logic [31:0] MIN_SPEED = 32'h00018000;
  localparam int          DIV_BITS  = 32;
  localparam int          LAT_PASS  = 2;
  localparam int          LAT_CLAMP = 2 + DIV_BITS;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] vx_in = '0;
  logic [31:0] vy_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] vx_out;
  logic [31:0] vy_out;
  logic [1:0]  clamp_flag;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] vx;
    logic [31:0] vy;
    logic [31:0] ex;
    logic [31:0] ey;
    logic [1:0]  fl;
    int          lat;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  boid_speed_clamp #(
    .MAX_SPEED (MAX_SPEED),
    .MIN_SPEED (MIN_SPEED),
    .DIV_BITS  (DIV_BITS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vx_in      (vx_in),
    .vy_in      (vy_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .vx_out     (vx_out),
    .vy_out     (vy_out),
    .clamp_flag (clamp_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference: speed estimate, clamp decision, ratio and scaling in plain integers.
  function automatic void model(input logic [31:0] vx, input logic [31:0] vy,
                                output logic [31:0] ex, output logic [31:0] ey,
                                output logic [1:0] fl, output int lat);
    longint sx, sy, ax, ay, mx, mn, sp, tgt, r;
    sx = longint'($signed(vx));
    sy = longint'($signed(vy));
    ax = (sx < 0) ? -sx : sx;
    ay = (sy < 0) ? -sy : sy;
    if (ax > 2147483647) ax = 2147483647;
    if (ay > 2147483647) ay = 2147483647;
    mx = (ax > ay) ? ax : ay;
    mn = (ax > ay) ? ay : ax;
    sp = mx + mn / 2;
    if (sp > 2147483647) sp = 2147483647;
    if (sp > longint'(MAX_SPEED)) begin
      tgt = longint'(MAX_SPEED);
      fl  = 2'b01;
    end else if (sp != 0 && sp < longint'(MIN_SPEED)) begin
      tgt = longint'(MIN_SPEED);
      fl  = 2'b10;
    end else begin
      ex  = vx;
      ey  = vy;
      fl  = 2'b00;
      lat = LAT_PASS;
      return;
    end
    r = (tgt * 32768) / sp;
    if (r > 2147483647) r = 2147483647;
    ex  = 32'((sx * r) >>> 15);
    ey  = 32'((sy * r) >>> 15);
    lat = LAT_CLAMP;
  endfunction

  // One full transaction; starts and ends on a falling edge.
  task automatic run_txn(input string tag, input logic [31:0] vx, input logic [31:0] vy,
                         input logic [31:0] ex, input logic [31:0] ey,
                         input logic [1:0] ef, input int elat, input int hold);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    vx_in    = vx;
    vy_in    = vy;
    @(negedge clk);
    in_valid = 1'b0;
    vx_in    = $urandom;
    vy_in    = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_vx"},      vx_out, ex);
    check({tag, "_vy"},      vy_out, ey);
    check({tag, "_flag"},    32'(clamp_flag), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        vx_in    = 32'h00040000;
        vy_in    = 32'h00000000;
      end
      if (i == 4) in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
      check({tag, "_hold_vx"},    vx_out, ex);
      check({tag, "_hold_vy"},    vy_out, ey);
      check({tag, "_hold_flag"},  32'(clamp_flag), 32'(ef));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  function automatic logic [31:0] rnd_vel();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom_range(0, 32'h00004000);
      1:       v = $urandom_range(0, 32'h00020000);
      2:       v = $urandom_range(0, 32'h00080000);
      default: v = $urandom;
    endcase
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ex, ey;
    logic [1:0]  fl;
    int          lat;
    int          seen;

    //            vx            vy            ex            ey            fl     lat
    tbl[0]  = '{32'h00040000, 32'h00000000, 32'h00030000, 32'h00000000, 2'b01, LAT_CLAMP};
    tbl[1]  = '{32'hFFFC0000, 32'h00000000, 32'hFFFD0000, 32'h00000000, 2'b01, LAT_CLAMP};
    tbl[2]  = '{32'h00008000, 32'h00008000, 32'h00010000, 32'h00010000, 2'b10, LAT_CLAMP};
    tbl[3]  = '{32'h00020000, 32'h00010000, 32'h00020000, 32'h00010000, 2'b00, LAT_PASS};
    tbl[4]  = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 2'b00, LAT_PASS};
    tbl[5]  = '{32'h00030000, 32'h00000000, 32'h00030000, 32'h00000000, 2'b00, LAT_PASS};
    tbl[6]  = '{32'h00018000, 32'h00000000, 32'h00018000, 32'h00000000, 2'b00, LAT_PASS};
    tbl[7]  = '{32'h00030001, 32'h00000000, 32'h0002FFFA, 32'h00000000, 2'b01, LAT_CLAMP};
    tbl[8]  = '{32'h80000000, 32'h00000000, 32'hFFFD0000, 32'h00000000, 2'b01, LAT_CLAMP};
    tbl[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0002FFFF, 32'h0002FFFF, 2'b01, LAT_CLAMP};
    tbl[10] = '{32'h00000001, 32'h00000000, 32'h0000FFFF, 32'h00000000, 2'b10, LAT_CLAMP};
    tbl[11] = '{32'hFFFF8000, 32'h00008000, 32'hFFFF0000, 32'h00010000, 2'b10, LAT_CLAMP};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),   32'd0);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_vx_out",    vx_out,          32'd0);
    check("rst_vy_out",    vy_out,          32'd0);
    check("rst_flag",      32'(clamp_flag), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Directed vectors
    foreach (tbl[i]) begin
      run_txn($sformatf("vec%0d", i), tbl[i].vx, tbl[i].vy,
              tbl[i].ex, tbl[i].ey, tbl[i].fl, tbl[i].lat, 0);
    end

    // Backpressure with an ignored second input pulse
    run_txn("bp", 32'h00040000, 32'h00000000, 32'h00030000, 32'h00000000,
            2'b01, LAT_CLAMP, 10);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp_no_second_txn", 32'(seen), 32'd0);

    // Reset during the divide phase of an over-max pair
    in_valid = 1'b1;
    vx_in    = 32'h00040000;
    vy_in    = 32'h00000000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid),  32'd0);
    check("midrst_vx_out",    vx_out,          32'd0);
    check("midrst_vy_out",    vy_out,          32'd0);
    check("midrst_flag",      32'(clamp_flag), 32'd0);
    check("midrst_in_ready",  32'(in_ready),   32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_output", 32'(seen), 32'd0);
    run_txn("after_rst", 32'h00020000, 32'h00010000, 32'h00020000, 32'h00010000,
            2'b00, LAT_PASS, 0);

    // Random pairs against the model
    for (int k = 0; k < 40; k++) begin
      logic [31:0] rvx, rvy;
      rvx = rnd_vel();
      rvy = rnd_vel();
      model(rvx, rvy, ex, ey, fl, lat);
      run_txn($sformatf("rnd%0d", k), rvx, rvy, ex, ey, fl, lat, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
